mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//  Multiply/divide unit for the pipelined MIPS core; sits in EX beside the ALU and consumes GRF busA/busB operands.
//  Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations into private HI/LO registers.
//  Handles MTHI/MTLO in a single cycle. Drives busy to the hazard unit, which stalls MD-class instructions in D.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy stays high for MULT/MULTU/MADD/MADDU (>=1)
//  DIV_CYCLES   10  cycles busy stays high for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   clock; all state updates on posedge
//  reset   in   1   asynchronous, active-low reset (0 = reset)
//  start   in   1   1-cycle request; op/a/b are sampled on the same edge
//  op      in   3   operation code, mdu_pkg::MDU_* encoding
//  a       in   32  operand rs (GRF busA after forwarding)
//  b       in   32  operand rt (GRF busB after forwarding)
//  busy    out  1   multi-cycle operation in progress
//  hi      out  32  HI register (MFHI source)
//  lo      out  32  LO register (MFLO source)
// BEHAVIOUR
//  - Reset (reset==0, async): busy=0, hi=0, lo=0, counter=0, latched operands=0.
//    Reset mid-operation aborts it; HI/LO stay 0 and no late write-back occurs.
//  - States: IDLE, RUN. Down-counter cnt[$clog2(max(MULT,DIV)+1)-1:0].
//  - IDLE + start + MULT/MULTU/DIV/DIVU/(MADD/MADDU) at edge E0:
//    latch op/a/b, load cnt=N (MULT_CYCLES or DIV_CYCLES), go to RUN.
//    busy=1 from E0 until edge E_N.
//  - RUN: cnt decrements each edge. On the edge where cnt 1->0:
//    write hi/lo, busy=0, go to IDLE. hi/lo keep old values while busy.
//  - MTHI/MTLO with start in IDLE: hi<=a (MTHI) / lo<=a (MTLO) at that edge; busy stays 0.
//  - start while busy=1: ignored, and latched operands are unchanged.
//    The hazard unit must never issue this; a bench assertion flags it.
//  - start with an undefined or disabled op: ignored; no state change.
//  - MULT: {hi,lo}=$signed(a)*$signed(b) (64-bit). MULTU: unsigned 64-bit product.
//  - DIV: lo=$signed quotient (truncated toward zero), hi=remainder (sign of a). DIVU: unsigned.
//  - Divide by zero (DIV/DIVU): lo=32'hFFFF_FFFF, hi=a. Runs full DIV_CYCLES.
//  - DIV overflow, a=32'h8000_0000 and b=32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
//  - Results come from the operands latched at E0, not from a/b during RUN.
// CONFIGURATION
//  - Macro MDU_MADD_EN, when defined:
//    MADD  {hi,lo} += signed a*b; MADDU {hi,lo} += unsigned a*b.
//    Both take MULT_CYCLES; the accumulate uses the hi/lo value at completion; 64-bit sum wraps mod 2^64.
//  - When undefined: the MADD/MADDU codes are treated as undefined ops and ignored (no busy, no write).
// STRUCTURE
//  - Package mdu_pkg: op localparams.
//    MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MADD=6, MDU_MADDU=7.
//    Also state encoding IDLE/RUN.
//  - Sub-module mdu_arith: purely combinational.
//    Inputs: latched op/a/b plus current hi/lo. Outputs: next hi/lo, including div-by-zero, overflow and MADD rules.
//    Top level holds the FSM, counter and registers.
// TESTING
//  1. MULT a=-3 (FFFF_FFFD), b=7:
//     busy high 5 cycles; then hi=FFFF_FFFF, lo=FFFF_FFEB; busy=0 on the same edge.
//  2. DIVU a=100, b=7: busy for 10 cycles; lo=14, hi=2.
//     DIV a=-7, b=2: lo=FFFF_FFFD, hi=FFFF_FFFF.
//  3. DIV a=5, b=0: lo=FFFF_FFFF, hi=5.
//     DIV a=8000_0000, b=FFFF_FFFF: lo=8000_0000, hi=0.
//  4. MTHI a=1234_5678 in IDLE: hi=1234_5678 next edge, busy never 1.
//     Then start MULTU with a/b changing during RUN: result uses the E0 operands.
//  5. MULT started, reset pulled low at cycle 3:
//     busy=0, hi=lo=0 immediately; after reset release, no write ever appears.
//  6. MDU_MADD_EN defined: hi=0, lo=FFFF_FFFF, MADDU a=1, b=1 -> hi=1, lo=0.
//     MDU_MADD_EN undefined: same stimulus leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and the op classifier. Optional MADD/MADDU support: macro MDU_MADD_EN.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_MADDU = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_multi(input logic [2:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU) ||
            (op == MDU_DIV)  || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: next HI/LO from latched op/operands.
// Ports: op, a, b, hi, lo in; hi_n, lo_n out. Macro MDU_MADD_EN adds MADD/MADDU.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'b0, a} * {32'b0, b};

    // Signed divide works on magnitudes; the overflow case
    // (-2^31 / -1) naturally yields quotient 8000_0000, remainder 0.
    assign sgn   = (op == MDU_DIV);
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;
    assign dvd   = sgn ? mag_a : a;
    // Divisor forced non-zero so the divider never sees x/0.
    assign dvs   = (b == 32'd0) ? 32'd1 : (sgn ? mag_b : b);
    assign uq    = dvd / dvs;
    assign ur    = dvd % dvs;
    assign sq    = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    assign sr    = a[31] ? (~ur + 32'd1) : ur;

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        case (op)
            MDU_MULT:  {hi_n, lo_n} = sprod;
            MDU_MULTU: {hi_n, lo_n} = uprod;
            MDU_DIV: begin
                if (b == 32'd0) begin
                    lo_n = 32'hFFFF_FFFF;
                    hi_n = a;
                end else begin
                    lo_n = sq;
                    hi_n = sr;
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    lo_n = 32'hFFFF_FFFF;
                    hi_n = a;
                end else begin
                    lo_n = uq;
                    hi_n = ur;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {hi_n, lo_n} = {hi, lo} + sprod;
            MDU_MADDU: {hi_n, lo_n} = {hi, lo} + uprod;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: FSM, down-counter, latched operands, HI/LO.
// Ports: clk, reset (async, active-low), start, op, a, b; busy, hi, lo.
// Macro MDU_MADD_EN enables MADD/MADDU accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);

    mdu_state_t  state;
    mdu_state_t  state_n;
    logic [CW-1:0] cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        go;
    logic        done;
    logic        mthi;
    logic        mtlo;

    assign go   = start && (state == IDLE) && is_multi(op);
    assign done = (state == RUN) && (cnt == CNT_ONE);
    assign mthi = start && (state == IDLE) && (op == MDU_MTHI);
    assign mtlo = start && (state == IDLE) && (op == MDU_MTLO);

    mdu_arith u_arith (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (hi),
        .lo   (lo),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go)   state_n = RUN;
            RUN:  if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (go) begin
            cnt  <= is_div(op) ? CNT_DIV : CNT_MUL;
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end else if (state == RUN) begin
            cnt  <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= hi_n;
            lo <= lo_n;
        end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Randomised scoreboard bench for mdu against a 64-bit arithmetic model.
// Works with or without MDU_MADD_EN defined.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on the architectural HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output bit acc, output int lat);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        acc = 1'b1;
        lat = 0;
        case (o)
            MDU_MULT:  begin p = sx * sy; {m_hi, m_lo} = p; lat = MC; end
            MDU_MULTU: begin p = ux * uy; {m_hi, m_lo} = p; lat = MC; end
            MDU_DIV, MDU_DIVU: begin
                lat = DC;
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = x;
                end else if (o == MDU_DIV) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    m_lo = 32'(sq);
                    m_hi = 32'(sr);
                end else begin
                    m_lo = 32'(ux / uy);
                    m_hi = 32'(ux % uy);
                end
            end
            MDU_MTHI: m_hi = x;
            MDU_MTLO: m_lo = x;
            default: begin
`ifdef MDU_MADD_EN
                if (o == MDU_MADD) p = sx * sy;
                else               p = ux * uy;
                p = {m_hi, m_lo} + p;
                {m_hi, m_lo} = p;
                lat = MC;
`else
                acc = 1'b0;
`endif
            end
        endcase
    endtask

    // Caller is at posedge+1. Operands are scrambled after the launch edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit   acc;
        int   lat;
        exp_t e;
        model(o, x, y, acc, lat);
        if (acc) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.lat = lat;
            q.push_back(e);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_after_start", {63'd0, busy}, {63'd0, (acc && lat > 0)});
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk); #1;
            a = $urandom;
            b = $urandom;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout op %0d got busy=1 want 0", o);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare on each completion (busy falling or an MTHI/MTLO write).
    initial begin
        logic prev_busy;
        logic pend_mt;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        pend_mt   = 1'b0;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                q.delete();
                prev_busy = 1'b0;
                pend_mt   = 1'b0;
                bcnt      = 0;
            end else begin
                assert (!(start && busy)) else $error("start issued while busy");
                if (pend_mt || (prev_busy && !busy)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write got hi=%h lo=%h want none", hi, lo);
                    end else begin
                        e = q.pop_front();
                        chk("hilo", {hi, lo}, {e.hi, e.lo});
                        chk("latency", 64'(bcnt), 64'(e.lat));
                    end
                    bcnt = 0;
                end
                if (busy) bcnt++;
                pend_mt   = start && !busy && (op == MDU_MTHI || op == MDU_MTLO);
                prev_busy = busy;
            end
        end
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(MDU_DIVU, 32'd100, 32'd7);
        chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_DIV, 32'd5, 32'd0);
        chk("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        issue(MDU_MULTU, 32'hDEAD_BEEF, 32'h0000_1000);

        // Abort a MULT with reset at its third busy cycle.
        start = 1'b1;
        op    = MDU_MULT;
        a     = 32'h0001_0001;
        b     = 32'h0003_0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("no_late_write", {hi, lo}, 64'd0);
        chk("no_late_busy", {63'd0, busy}, 64'd0);

        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MDU_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("maddu_carry", {hi, lo}, {32'd1, 32'd0});
`else
        chk("madd_disabled", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

        for (int n = 0; n < 80; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: rb = -32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(ro, ra, rb);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
